pixel_ray_sequencer: RTL and testbench

Frame-level front end of the ray pipeline. On a start pulse it scans every pixel of the projection plane in raster order and drives x/y into the eye-to-pixel direction stage. That stage has no input valid and cannot stall, so this block tracks which outputs are real with a latency-matched valid delay line. It re-tags each returned direction with its pixel coordinates and buffers the result behind a valid/ready handshake for the intersection stage.

---
 rtl/ray_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/pixel_ray_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pixel_ray_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types for the pixel ray front end: pixel tags, tagged rays and the
// sequencer state encoding.
package ray_pkg;

  localparam int FLOAT_W      = 32;
  localparam int H_PIXELS_DEF = 512;
  localparam int V_PIXELS_DEF = 384;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } pixel_tag_t;

  typedef struct packed {
    pixel_tag_t         tag;
    logic [FLOAT_W-1:0] dir_x;
    logic [FLOAT_W-1:0] dir_y;
    logic [FLOAT_W-1:0] dir_z;
  } ray_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is visible on
// rdata whenever empty is low. Push when full and pop when empty are dropped.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_ray_sequencer.sv
// Raster-scans the projection plane into a non-stallable direction stage,
// re-tags returned directions with their pixel and queues them as rays.
module pixel_ray_sequencer
  import ray_pkg::*;
#(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int V_PIXELS     = V_PIXELS_DEF,
  parameter int PIPE_LATENCY = 64,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic [10:0]        x_out,
  output logic [9:0]         y_out,
  output logic               issue_valid_out,
  input  logic [FLOAT_W-1:0] dir_x_in,
  input  logic [FLOAT_W-1:0] dir_y_in,
  input  logic [FLOAT_W-1:0] dir_z_in,
  input  logic               dir_valid_in,
  output logic [10:0]        ray_x_out,
  output logic [9:0]         ray_y_out,
  output logic [FLOAT_W-1:0] ray_dir_x_out,
  output logic [FLOAT_W-1:0] ray_dir_y_out,
  output logic [FLOAT_W-1:0] ray_dir_z_out,
  output logic               ray_valid_out,
  input  logic               ray_ready_in,
  output logic               err_out,
  output state_t             state_dbg_out
);

  localparam int          CW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [10:0] X_LAST = 11'(H_PIXELS - 1);
  localparam logic [9:0]  Y_LAST = 10'(V_PIXELS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [10:0]             x_cnt;
  logic [9:0]              y_cnt;
  logic [CW-1:0]           credit;
  logic [PIPE_LATENCY-1:0] delay_line;
  logic                    issue;
  logic                    pop;
  logic                    tap;
  logic                    drain_done;
  logic                    last_pixel;
  pixel_tag_t              issue_tag;
  pixel_tag_t              tag_head;
  logic                    tag_full;
  logic                    tag_empty;
  ray_t                    ray_in;
  ray_t                    ray_head;
  logic                    res_full;
  logic                    res_empty;

  // Ray handshake: ray_valid_out is high whenever a ray is queued and the
  // head ray is stable until consumed; a transfer happens on a clock edge
  // where ray_valid_out and ray_ready_in are both high.
  assign pop        = ray_valid_out && ray_ready_in;
  assign tap        = delay_line[PIPE_LATENCY-1];
  assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign issue_tag  = '{x: x_cnt, y: y_cnt};
  assign ray_in     = '{tag: tag_head, dir_x: dir_x_in, dir_y: dir_y_in, dir_z: dir_z_in};

  assign busy_out      = (state == SCAN) || (state == DRAIN);
  assign state_dbg_out = state;
  assign ray_valid_out = !res_empty;
  assign ray_x_out     = ray_head.tag.x;
  assign ray_y_out     = ray_head.tag.y;
  assign ray_dir_x_out = ray_head.dir_x;
  assign ray_dir_y_out = ray_head.dir_y;
  assign ray_dir_z_out = ray_head.dir_z;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  // Credit bounds rays in flight plus rays queued, so neither FIFO can overflow.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: if (start_in) state_next = SCAN;
      SCAN: begin
        if ((credit < CW'(FIFO_DEPTH)) && !tag_full) begin
          issue = 1'b1;
          if (last_pixel) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (credit == '0) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_cnt           <= '0;
      y_cnt           <= '0;
      x_out           <= '0;
      y_out           <= '0;
      issue_valid_out <= 1'b0;
      frame_done_out  <= 1'b0;
      credit          <= '0;
      delay_line      <= '0;
      err_out         <= 1'b0;
    end else begin
      issue_valid_out <= issue;
      frame_done_out  <= drain_done;
      if ((state == IDLE) && start_in) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (issue) begin
        x_out <= x_cnt;
        y_out <= y_cnt;
        if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == Y_LAST) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      case ({issue, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: credit <= credit;
      endcase
      // The direction stage has no valid input; this shift tracks which of
      // its outputs correspond to real pixels.
      delay_line[0] <= issue_valid_out;
      for (int i = 1; i < PIPE_LATENCY; i++) delay_line[i] <= delay_line[i-1];
      if (tap && (!dir_valid_in || tag_empty || res_full)) err_out <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(pixel_tag_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (issue),
    .wdata (issue_tag),
    .pop   (tap),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sync_fifo #(
    .WIDTH ($bits(ray_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk   (clk_in),
    .rst_n (rst_in),
    .push  (tap),
    .wdata (ray_in),
    .pop   (pop),
    .rdata (ray_head),
    .full  (res_full),
    .empty (res_empty)
  );

endmodule

// File: tb/tb_pixel_ray_sequencer.sv
// Self-checking bench: 4x3 frame, 5-cycle stub direction stage, 8-deep FIFOs.
module tb_pixel_ray_sequencer;
  import ray_pkg::*;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int L  = 5;
  localparam int D  = 8;
  localparam int RW = $bits(ray_t);
  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b0;
  logic               start_in = 1'b0;
  logic               ray_ready_in = 1'b0;
  logic               dir_valid_in = 1'b0;
  logic [FLOAT_W-1:0] dir_x_in = '0;
  logic [FLOAT_W-1:0] dir_y_in = '0;
  logic [FLOAT_W-1:0] dir_z_in = '0;
  logic               busy_out, frame_done_out, issue_valid_out, ray_valid_out, err_out;
  logic [10:0]        x_out, ray_x_out;
  logic [9:0]         y_out, ray_y_out;
  logic [FLOAT_W-1:0] ray_dir_x_out, ray_dir_y_out, ray_dir_z_out;
  state_t             state_dbg_out;

  pixel_ray_sequencer #(
    .H_PIXELS(H), .V_PIXELS(V), .PIPE_LATENCY(L), .FIFO_DEPTH(D)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .x_out(x_out), .y_out(y_out),
    .issue_valid_out(issue_valid_out), .dir_x_in(dir_x_in), .dir_y_in(dir_y_in),
    .dir_z_in(dir_z_in), .dir_valid_in(dir_valid_in), .ray_x_out(ray_x_out),
    .ray_y_out(ray_y_out), .ray_dir_x_out(ray_dir_x_out), .ray_dir_y_out(ray_dir_y_out),
    .ray_dir_z_out(ray_dir_z_out), .ray_valid_out(ray_valid_out),
    .ray_ready_in(ray_ready_in), .err_out(err_out), .state_dbg_out(state_dbg_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int iss_cnt, pop_cnt, frames, ret_cnt;
  int first_iss, last_iss, first_ray;
  logic exp_err = 1'b0;
  logic prev_busy = 1'b0;
  logic junk_mode = 1'b0;
  logic drop_mode = 1'b0;

  // scoreboard state
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  logic [20:0]   iss_q[$];
  logic [21:0]   hist_q[$];
  int            arr_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] fbits(input int v);
    case (v)
      0:       return 32'h0000_0000;
      1:       return 32'h3F80_0000;
      2:       return 32'h4000_0000;
      3:       return 32'h4040_0000;
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  function automatic logic [RW-1:0] mk_ray(input logic [10:0] x, input logic [9:0] y,
                                           input logic [31:0] dx, input logic [31:0] dy,
                                           input logic [31:0] dz);
    ray_t r;
    r.tag.x = x;
    r.tag.y = y;
    r.dir_x = dx;
    r.dir_y = dy;
    r.dir_z = dz;
    return r;
  endfunction

  // Behavioural model: a frame is the raster list of pixels, each ray carrying
  // float(x), float(y), 1.0 as the stub direction stage computes.
  task automatic model_reset();
    exp_q.delete(); got_q.delete(); iss_q.delete(); arr_q.delete();
    iss_cnt = 0; pop_cnt = 0; exp_err = 1'b0;
    first_iss = -1; last_iss = -1; first_ray = -1;
  endtask

  task automatic model_frame();
    model_reset();
    exp_err = err_out;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        iss_q.push_back({11'(x), 10'(y)});
        exp_q.push_back(mk_ray(11'(x), 10'(y), fbits(x), fbits(y), ONE));
      end
    end
  endtask

  // compare process plus stub direction stage, both at the negative edge
  always @(negedge clk_in) begin
    logic [RW-1:0] got;
    logic [21:0]   h;
    logic          exp_valid;
    cyc++;
    if (rst_in) begin
      chk("err_out", 128'(err_out), 128'(exp_err));
      if (issue_valid_out) begin
        iss_cnt++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        arr_q.push_back(cyc);
        if (iss_q.size() == 0) chk("issue_count_max", 128'(iss_cnt), 128'(H * V));
        else chk("issue_pixel", 128'({x_out, y_out}), 128'(iss_q.pop_front()));
      end
      chk("credit_bound", 128'(iss_cnt - pop_cnt <= D), 128'(1'b1));
      exp_valid = (arr_q.size() > 0) && (arr_q[0] + L + 1 <= cyc);
      chk("ray_valid", 128'(ray_valid_out), 128'(exp_valid));
      if (ray_valid_out && first_ray < 0) first_ray = cyc;
      if (ray_valid_out && ray_ready_in) begin
        got = mk_ray(ray_x_out, ray_y_out, ray_dir_x_out, ray_dir_y_out, ray_dir_z_out);
        got_q.push_back(got);
        pop_cnt++;
        if (arr_q.size() > 0) void'(arr_q.pop_front());
        if (exp_q.size() == 0) chk("ray_count_max", 128'(pop_cnt), 128'(H * V));
        else chk("ray", 128'(got), 128'(exp_q.pop_front()));
      end
      if (frame_done_out) begin
        frames++;
        chk("busy_at_done", 128'(busy_out), 128'(1'b0));
        chk("busy_before_done", 128'(prev_busy), 128'(1'b1));
        chk("rays_left_at_done", 128'(exp_q.size()), 128'(0));
      end
      prev_busy = busy_out;
    end else begin
      prev_busy = 1'b0;
    end
    // stub: returns what was presented L cycles ago, junk otherwise
    hist_q.push_back({issue_valid_out, x_out, y_out});
    dir_valid_in = junk_mode;
    dir_x_in = JUNK; dir_y_in = JUNK; dir_z_in = JUNK;
    if (hist_q.size() > L) begin
      h = hist_q.pop_front();
      if (h[21]) begin
        dir_valid_in = 1'b1;
        dir_x_in = fbits(int'(h[20:10]));
        dir_y_in = fbits(int'(h[9:0]));
        dir_z_in = ONE;
        if (drop_mode) begin
          ret_cnt++;
          if (ret_cnt == 3) begin
            dir_valid_in = 1'b0;
            exp_err = 1'b1;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_frame();
    logic seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (frame_done_out) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", 128'(seen), 128'(1'b1));
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 128'(busy_out), 128'(0));
    chk({tag, "_done"}, 128'(frame_done_out), 128'(0));
    chk({tag, "_xy"}, 128'({x_out, y_out}), 128'(0));
    chk({tag, "_issue"}, 128'(issue_valid_out), 128'(0));
    chk({tag, "_ray_valid"}, 128'(ray_valid_out), 128'(0));
    chk({tag, "_ray"}, 128'(mk_ray(ray_x_out, ray_y_out, ray_dir_x_out, ray_dir_y_out,
                                   ray_dir_z_out)), 128'(0));
    chk({tag, "_err"}, 128'(err_out), 128'(0));
    chk({tag, "_state"}, 128'(state_dbg_out), 128'(IDLE));
  endtask

  initial begin
    int fb;
    logic found;
    frames = 0; ret_cnt = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #2;
    check_reset_outputs("por");
    rst_in = 1'b1;
    tick();

    // full-rate frame
    ray_ready_in = 1'b1;
    model_frame();
    pulse_start();
    wait_frame();
    chk("a_rays", 128'(pop_cnt), 128'(12));
    chk("a_frames", 128'(frames), 128'(1));
    chk("a_latency", 128'(first_ray - first_iss), 128'(6));
    chk("a_issue_span", 128'(last_iss - first_iss), 128'(11));
    chk("a_ray0", 128'(got_q[0]), 128'(mk_ray(11'd0, 10'd0, 32'h0, 32'h0, 32'h3F80_0000)));
    chk("a_ray4", 128'(got_q[4]), 128'(mk_ray(11'd0, 10'd1, 32'h0, 32'h3F80_0000, 32'h3F80_0000)));
    chk("a_ray11", 128'(got_q[11]),
        128'(mk_ray(11'd3, 10'd2, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000)));
    chk("a_state", 128'(state_dbg_out), 128'(IDLE));

    // back-pressure: credits stop issue at FIFO_DEPTH
    ray_ready_in = 1'b0;
    model_frame();
    pulse_start();
    repeat (40) tick();
    chk("b_issued", 128'(iss_cnt), 128'(8));
    chk("b_issue_low", 128'(issue_valid_out), 128'(0));
    chk("b_ray_valid", 128'(ray_valid_out), 128'(1));
    chk("b_state", 128'(state_dbg_out), 128'(SCAN));
    ray_ready_in = 1'b1;
    wait_frame();
    chk("b_rays", 128'(pop_cnt), 128'(12));
    chk("b_err", 128'(err_out), 128'(0));

    // junk on dir_valid_in all the time
    junk_mode = 1'b1;
    repeat (10) tick();
    model_frame();
    pulse_start();
    wait_frame();
    chk("c_rays", 128'(pop_cnt), 128'(12));
    chk("c_err", 128'(err_out), 128'(0));
    junk_mode = 1'b0;

    // missing valid on the third real return
    drop_mode = 1'b1;
    ret_cnt = 0;
    model_frame();
    pulse_start();
    wait_frame();
    drop_mode = 1'b0;
    chk("d_rays", 128'(pop_cnt), 128'(12));
    chk("d_err_sticky", 128'(err_out), 128'(1));
    rst_in = 1'b0;
    #1;
    check_reset_outputs("d_rst");
    model_reset();
    tick();
    rst_in = 1'b1;
    tick();

    // reset in the middle of a scan
    model_frame();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (issue_valid_out && x_out == 11'd2 && y_out == 10'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("e_reached_2_1", 128'(found), 128'(1'b1));
    rst_in = 1'b0;
    #1;
    check_reset_outputs("e_rst");
    model_reset();
    repeat (2) tick();
    rst_in = 1'b1;
    tick();
    model_frame();
    pulse_start();
    wait_frame();
    chk("e_rays", 128'(pop_cnt), 128'(12));
    chk("e_issues", 128'(iss_cnt), 128'(12));

    // start pulses during SCAN and DRAIN are ignored
    model_frame();
    fb = frames;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    for (int i = 0; i < 100 && iss_cnt < 12; i++) tick();
    chk("f_drain_busy", 128'(state_dbg_out), 128'(DRAIN));
    pulse_start();
    wait_frame();
    repeat (20) tick();
    chk("f_one_done", 128'(frames - fb), 128'(1));
    chk("f_issues", 128'(iss_cnt), 128'(12));
    chk("f_busy", 128'(busy_out), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
